// File: rtl/tsp_pkg.sv
// tsp_pkg: shared constants and types for the TSP city loader and solver.
//   N_CITIES / COORD_W / IDX_W : default city-set geometry
//   coord_t                    : one coordinate (one stream byte)
//   loader_state_t             : loader FSM states (GEN exists only when
//                                TSP_LOADER_LFSR_EN is defined)
//   LFSR_SEED / LFSR_TAPS      : on-chip city generator constants
package tsp_pkg;

  localparam int N_CITIES = 64;
  localparam int COORD_W  = 8;
  localparam int IDX_W    = 6;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV_X = 3'd1,
    RECV_Y = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
`ifdef TSP_LOADER_LFSR_EN
    , GEN  = 3'd5
`endif
  } loader_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci register map onto
  // register bits 0,2,3,5; the feedback bit is the parity of q & LFSR_TAPS.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/tsp_lfsr16.sv
// tsp_lfsr16: 16-bit Fibonacci LFSR used to generate a pseudo-random city set.
// Only built when TSP_LOADER_LFSR_EN is defined.
// Ports:
//   clk, rst : clock, synchronous active-high reset (reset value LFSR_SEED)
//   enable   : advance one step
//   load     : load seed (wins over enable)
//   seed     : value loaded by load
//   q        : current register value
`ifdef TSP_LOADER_LFSR_EN
module tsp_lfsr16
  import tsp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic feedback;

  assign feedback = ^(q & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= seed;
    end else if (enable) begin
      q <= {feedback, q[15:1]};
    end
  end

endmodule
`endif

// File: rtl/tsp_city_loader.sv
// tsp_city_loader: receives a byte stream x0,y0,...,x(N-1),y(N-1) over a
// valid/ready handshake and fills the xs/ys arrays feeding the TSP solver.
// The solver is held in reset until a complete, correctly framed set is in.
// Optional feature macro: TSP_LOADER_LFSR_EN (adds gen_start and an on-chip
// LFSR city generator).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : pulse, begin a new load (clears counters and flags)
//   gen_start         : pulse, generate a city set from the LFSR (macro only)
//   in_data/in_valid/in_last, in_ready : byte stream handshake
//   xs, ys            : city coordinate arrays
//   solver_rst        : reset to the solver, low only when a set is complete
//   load_done/load_err: completion / framing-error levels
//   city_cnt          : cities written since the last start
//   checksum          : mod-2^16 sum of accepted (or generated) bytes
module tsp_city_loader #(
  parameter int N_CITIES = tsp_pkg::N_CITIES,
  parameter int COORD_W  = tsp_pkg::COORD_W,
  parameter int IDX_W    = tsp_pkg::IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef TSP_LOADER_LFSR_EN
  input  logic               gen_start,
`endif
  input  logic [COORD_W-1:0] in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [COORD_W-1:0] xs [N_CITIES],
  output logic [COORD_W-1:0] ys [N_CITIES],
  output logic               solver_rst,
  output logic               load_done,
  output logic               load_err,
  output logic [IDX_W:0]     city_cnt,
  output logic [15:0]        checksum
);

  import tsp_pkg::*;

  loader_state_t      state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [COORD_W-1:0] x_hold;
  logic               clear;
  logic               accept;
  logic               last_city;

`ifdef TSP_LOADER_LFSR_EN
  logic [15:0] lfsr_q;

  assign clear = start | gen_start;

  tsp_lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (state == GEN),
    .load   (gen_start & ~start),
    .seed   (LFSR_SEED),
    .q      (lfsr_q)
  );
`else
  assign clear = start;
`endif

  // A start pulse takes priority over a same-cycle byte, so ready is
  // dropped on that cycle to keep the handshake honest with the source.
  assign in_ready   = ~rst & ~clear & ((state == RECV_X) | (state == RECV_Y));
  assign accept     = in_valid & in_ready;
  assign last_city  = (idx == IDX_W'(N_CITIES - 1));
  assign solver_rst = rst | (state != DONE);
  assign load_done  = (state == DONE);
  assign load_err   = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RECV_X;
`ifdef TSP_LOADER_LFSR_EN
    end else if (gen_start) begin
      state_next = GEN;
`endif
    end else begin
      case (state)
        RECV_X: begin
          if (accept) state_next = in_last ? ERR : RECV_Y;
        end
        RECV_Y: begin
          // Framing is good only when in_last coincides with the final y.
          if (accept) begin
            if (last_city) state_next = in_last ? DONE : ERR;
            else           state_next = in_last ? ERR : RECV_X;
          end
        end
`ifdef TSP_LOADER_LFSR_EN
        GEN: begin
          if (last_city) state_next = DONE;
        end
`endif
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      x_hold   <= '0;
      city_cnt <= '0;
      checksum <= '0;
      for (int i = 0; i < N_CITIES; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
      end
    end else if (clear) begin
      // xs/ys deliberately keep their contents until overwritten.
      idx      <= '0;
      x_hold   <= '0;
      city_cnt <= '0;
      checksum <= '0;
    end else begin
      if (accept) begin
        checksum <= checksum + 16'(in_data);
        if (state == RECV_X) begin
          x_hold <= in_data;
        end else begin
          xs[idx]  <= x_hold;
          ys[idx]  <= in_data;
          city_cnt <= city_cnt + (IDX_W+1)'(1);
          idx      <= idx + IDX_W'(1);
        end
      end
`ifdef TSP_LOADER_LFSR_EN
      if (state == GEN) begin
        xs[idx]  <= COORD_W'(lfsr_q[7:0]);
        ys[idx]  <= COORD_W'(lfsr_q[15:8]);
        checksum <= checksum + 16'(lfsr_q[7:0]) + 16'(lfsr_q[15:8]);
        city_cnt <= city_cnt + (IDX_W+1)'(1);
        idx      <= idx + IDX_W'(1);
      end
`endif
    end
  end

endmodule
